// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-to-serial frame transmitter.
// Frame = start(0) | WIDTH data bits (MSB- or LSB-first) | optional even parity | stop(1).
// Every bit is held for CLKS_PER_BIT clocks. All outputs are registered.
module serial_frame_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic             clk,
  input  logic             async_reset,
  input  logic [WIDTH-1:0] parallel_data_input,
  input  logic             msb_first,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_data_output,
  output logic             busy,
  output logic             done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int DW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [DW-1:0] DATA_LAST = DW'(WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t           state_q;
  logic [CW-1:0]    bit_cnt_q;
  logic [DW-1:0]    data_cnt_q;
  logic [WIDTH-1:0] shreg_q;
  logic             msb_q;
  logic             parity_q;
  logic             line_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;

  logic             period_end_d;
  logic [WIDTH-1:0] shreg_d;
  logic             next_bit_d;

  // Shifted register and the bit it exposes for the next data period.
  always_comb begin
    period_end_d = (bit_cnt_q == BIT_LAST);
    shreg_d      = msb_q ? (shreg_q << 1) : (shreg_q >> 1);
    next_bit_d   = msb_q ? shreg_d[WIDTH-1] : shreg_d[0];
  end

  // Frame FSM; line, ready, busy and done are registered alongside the state.
  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      data_cnt_q <= '0;
      shreg_q    <= '0;
      msb_q      <= 1'b0;
      parity_q   <= 1'b0;
      line_q     <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (load_valid && ready_q) begin
            state_q    <= S_START;
            shreg_q    <= parallel_data_input;
            msb_q      <= msb_first;
            parity_q   <= ^parallel_data_input;
            bit_cnt_q  <= '0;
            data_cnt_q <= '0;
            line_q     <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_START: begin
          if (period_end_d) begin
            bit_cnt_q  <= '0;
            data_cnt_q <= '0;
            state_q    <= S_DATA;
            line_q     <= msb_q ? shreg_q[WIDTH-1] : shreg_q[0];
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (period_end_d) begin
            bit_cnt_q <= '0;
            if (data_cnt_q == DATA_LAST) begin
              data_cnt_q <= '0;
              if (PARITY_EN != 0) begin
                state_q <= S_PARITY;
                line_q  <= parity_q;
              end else begin
                state_q <= S_STOP;
                line_q  <= 1'b1;
              end
            end else begin
              data_cnt_q <= data_cnt_q + 1'b1;
              shreg_q    <= shreg_d;
              line_q     <= next_bit_d;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        S_PARITY: begin
          if (period_end_d) begin
            bit_cnt_q <= '0;
            state_q   <= S_STOP;
            line_q    <= 1'b1;
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (period_end_d) begin
            bit_cnt_q <= '0;
            state_q   <= S_IDLE;
            line_q    <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          line_q  <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign serial_data_output = line_q;
  assign load_ready         = ready_q;
  assign busy               = busy_q;
  assign done               = done_q;

endmodule
